// File: rtl/card_grid.sv
// card_grid: ROWS x COLS lianliankan card array.
// Each card has its own state (NORM/SEL/BLINK/HID). The grid also holds a
// shared mismatch-blink timer, a selection counter and a remaining-card counter.
// Per-card buses are flat and indexed i = row*COLS + col.
// Optional build macro: CARD_GRID_RESTART_EN adds a synchronous 'restart' input
// that reinitialises the whole grid and takes priority over ms/mf/s.
module card_grid #(
    parameter int ROWS         = 6,
    parameter int COLS         = 6,
    parameter int BLINK_CYCLES = 50000000,
    parameter int BLINK_TOGGLE = 6250000
) (
    input  logic                             clk,
    input  logic                             rst,
`ifdef CARD_GRID_RESTART_EN
    input  logic                             restart,
`endif
    input  logic                             s,
    input  logic [ROWS*COLS-1:0]             cur_bus,
    input  logic                             ms,
    input  logic                             mf,
    output logic [ROWS*COLS-1:0]             sel_bus,
    output logic [ROWS*COLS-1:0]             blink_bus,
    output logic [ROWS*COLS-1:0]             hidden_bus,
    output logic [1:0]                       sel_cnt,
    output logic                             pair_ready,
    output logic                             busy,
    output logic [$clog2(ROWS*COLS+1)-1:0]   remaining,
    output logic                             all_clear,
    output logic                             cur_err
);

    localparam int N   = ROWS * COLS;
    localparam int CW  = $clog2(N + 1);
    localparam int TW  = $clog2(BLINK_CYCLES);
    localparam int TGW = $clog2(BLINK_TOGGLE + 1);

    typedef enum logic [1:0] {
        NORM  = 2'd0,
        SEL   = 2'd1,
        BLINK = 2'd2,
        HID   = 2'd3
    } card_st_t;

    card_st_t        card_q [N];
    card_st_t        card_d [N];
    logic [1:0]      sel_q,  sel_d;
    logic [CW-1:0]   rem_q,  rem_d;
    logic            busy_q, busy_d;
    logic [TW-1:0]   tmr_q,  tmr_d;
    logic [TGW-1:0]  tog_q,  tog_d;
    logic            ph_q,   ph_d;
    logic            err_q,  err_d;
    logic            cur_ok;

    assign cur_ok = $onehot(cur_bus);

    // State registers for every card plus the shared counters and blink timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                card_q[i] <= NORM;
            end
            sel_q  <= '0;
            rem_q  <= CW'(N);
            busy_q <= 1'b0;
            tmr_q  <= '0;
            tog_q  <= '0;
            ph_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                card_q[i] <= card_d[i];
            end
            sel_q  <= sel_d;
            rem_q  <= rem_d;
            busy_q <= busy_d;
            tmr_q  <= tmr_d;
            tog_q  <= tog_d;
            ph_q   <= ph_d;
            err_q  <= err_d;
        end
    end

    // Next-state: blink window progress, then ms > mf > s event handling.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            card_d[i] = card_q[i];
        end
        sel_d  = sel_q;
        rem_d  = rem_q;
        busy_d = busy_q;
        tmr_d  = tmr_q;
        tog_d  = tog_q;
        ph_d   = ph_q;
        err_d  = s && !cur_ok;

        if (busy_q) begin
            if (tmr_q == '0) begin
                busy_d = 1'b0;
                ph_d   = 1'b0;
                tog_d  = '0;
                for (int unsigned i = 0; i < N; i++) begin
                    if (card_q[i] == BLINK) begin
                        card_d[i] = NORM;
                    end
                end
            end else begin
                tmr_d = tmr_q - 1'b1;
                if (tog_q == TGW'(BLINK_TOGGLE - 1)) begin
                    tog_d = '0;
                    ph_d  = ~ph_q;
                end else begin
                    tog_d = tog_q + 1'b1;
                end
            end
        end

        // sel_cnt can only reach 2 while idle, so ms/mf never race the window.
        if (ms && sel_q == 2'd2) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (card_q[i] == SEL) begin
                    card_d[i] = HID;
                end
            end
            sel_d = 2'd0;
            rem_d = rem_q - CW'(2);
        end else if (mf && sel_q == 2'd2) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (card_q[i] == SEL) begin
                    card_d[i] = BLINK;
                end
            end
            sel_d  = 2'd0;
            busy_d = 1'b1;
            tmr_d  = TW'(BLINK_CYCLES - 1);
            tog_d  = '0;
            ph_d   = 1'b1;
        end else if (s && !busy_q && !ms && !mf && cur_ok) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (cur_bus[i]) begin
                    if (card_q[i] == NORM && sel_q != 2'd2) begin
                        card_d[i] = SEL;
                        sel_d     = sel_q + 2'd1;
                    end else if (card_q[i] == SEL) begin
                        card_d[i] = NORM;
                        sel_d     = sel_q - 2'd1;
                    end
                end
            end
        end

`ifdef CARD_GRID_RESTART_EN
        if (restart) begin
            for (int unsigned i = 0; i < N; i++) begin
                card_d[i] = NORM;
            end
            sel_d  = 2'd0;
            rem_d  = CW'(N);
            busy_d = 1'b0;
            tmr_d  = '0;
            tog_d  = '0;
            ph_d   = 1'b0;
            err_d  = 1'b0;
        end
`endif
    end

    // Per-card output decode straight from the state registers.
    always_comb begin
        sel_bus    = '0;
        blink_bus  = '0;
        hidden_bus = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sel_bus[i]    = (card_q[i] == SEL);
            blink_bus[i]  = (card_q[i] == BLINK) && ph_q;
            hidden_bus[i] = (card_q[i] == HID);
        end
    end

    assign sel_cnt    = sel_q;
    assign pair_ready = (sel_q == 2'd2);
    assign busy       = busy_q;
    assign remaining  = rem_q;
    assign all_clear  = (rem_q == '0);
    assign cur_err    = err_q;

endmodule
